glb_axi_slave: RTL and testbench

- AXI4 slave (responder) that terminates the DMA bursts issued by the controller's AXI master toward the Global Buffer.
- Converts AW/W/B and AR/R bursts into single-word accesses on the GLB SRAM port: 32-bit byte address, 32-bit data, 4-bit active-low byte write enable.
- Serves exactly one transaction at a time, so ordering between reads and writes is trivially preserved.

---
 rtl/glb_axi_slave.sv | 190 +++++++++++++++++++
 tb/tb_glb_axi_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_axi_slave.sv
// glb_axi_slave: AXI4 slave terminating DMA bursts as single-word GLB SRAM accesses, one burst at a time.
// W beat -> GLB write next cycle, B two cycles after last W; AR -> first R at +3, then 3 cycles/beat.
// B and R are held until ready. Define GLB_AXI_SLV_ERR_EN for DECERR/SLVERR responses.
module glb_axi_slave #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] GLB_BASE   = '0,
  parameter int                    GLB_BYTES  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid_s_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_s_i,
  input  logic [LEN_WIDTH-1:0]    awlen_s_i,
  input  logic [2:0]              awsize_s_i,
  input  logic [1:0]              awburst_s_i,
  input  logic                    awvalid_s_i,
  output logic                    awready_s_o,
  input  logic [DATA_WIDTH-1:0]   wdata_s_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_s_i,
  input  logic                    wlast_s_i,
  input  logic                    wvalid_s_i,
  output logic                    wready_s_o,
  output logic [ID_WIDTH-1:0]     bid_s_o,
  output logic [1:0]              bresp_s_o,
  output logic                    bvalid_s_o,
  input  logic                    bready_s_i,
  input  logic [ID_WIDTH-1:0]     arid_s_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_s_i,
  input  logic [LEN_WIDTH-1:0]    arlen_s_i,
  input  logic [2:0]              arsize_s_i,
  input  logic [1:0]              arburst_s_i,
  input  logic                    arvalid_s_i,
  output logic                    arready_s_o,
  output logic [ID_WIDTH-1:0]     rid_s_o,
  output logic [DATA_WIDTH-1:0]   rdata_s_o,
  output logic [1:0]              rresp_s_o,
  output logic                    rlast_s_o,
  output logic                    rvalid_s_o,
  input  logic                    rready_s_i,
  output logic                    glb_en_o,
  output logic [ADDR_WIDTH-1:0]   glb_addr_o,
  output logic [DATA_WIDTH-1:0]   glb_write_data_o,
  output logic [DATA_WIDTH/8-1:0] glb_web_o,
  input  logic [DATA_WIDTH-1:0]   glb_read_data_i
);
  localparam logic [ADDR_WIDTH-1:0] LOC_MASK = ADDR_WIDTH'(GLB_BYTES - 1) & ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_CAP, RD_DATA} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt, aw_off, ar_off;
  logic [LEN_WIDTH-1:0]  len_q, beat_q;
  logic [1:0]            burst_q, err_q, aw_err, ar_err, w_err;
  logic                  beat_last, aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic                  oob_cur, oob_nxt, oob_ar;

  assign awready_s_o = (state_q == IDLE) && !rst;
  assign arready_s_o = (state_q == IDLE) && !rst && !awvalid_s_i;
  assign aw_hs = awvalid_s_i && awready_s_o;
  assign ar_hs = arvalid_s_i && arready_s_o;
  assign w_hs  = (state_q == WR_DATA) && wvalid_s_i && wready_s_o;
  assign b_hs  = bvalid_s_o && bready_s_i;
  assign r_hs  = rvalid_s_o && rready_s_i;

  // Offsets are kept unmasked so an out-of-window beat is still detectable; the GLB port sees them masked.
  assign aw_off    = (awaddr_s_i - GLB_BASE) & ~ADDR_WIDTH'(3);
  assign ar_off    = (araddr_s_i - GLB_BASE) & ~ADDR_WIDTH'(3);
  assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_WIDTH'(4);
  assign beat_last = (beat_q == len_q);

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef GLB_AXI_SLV_ERR_EN
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(GLB_BYTES);
  assign oob_cur = ({1'b0, addr_q}   >= SPAN);
  assign oob_nxt = ({1'b0, addr_nxt} >= SPAN);
  assign oob_ar  = ({1'b0, ar_off}   >= SPAN);
  assign aw_err  = (awsize_s_i != 3'b010 || awburst_s_i == 2'b11) ? 2'b10 : 2'b00;
  assign ar_err  = (arsize_s_i != 3'b010 || arburst_s_i == 2'b11) ? 2'b10 : 2'b00;
  assign w_err   = oob_cur ? 2'b11 : ((wlast_s_i != beat_last) ? 2'b10 : 2'b00);
`else
  logic unused_chk;
  assign unused_chk = ^{awsize_s_i, arsize_s_i, wlast_s_i};
  assign oob_cur = 1'b0;
  assign oob_nxt = 1'b0;
  assign oob_ar  = 1'b0;
  assign aw_err  = 2'b00;
  assign ar_err  = 2'b00;
  assign w_err   = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = WR_DATA;
               else if (ar_hs) state_d = RD_REQ;
      WR_DATA: if (w_hs && beat_last) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      RD_REQ:  state_d = RD_CAP;
      RD_CAP:  state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = rlast_s_o ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q           <= '0;
      len_q            <= '0;
      beat_q           <= '0;
      burst_q          <= '0;
      err_q            <= '0;
      wready_s_o       <= 1'b0;
      bvalid_s_o       <= 1'b0;
      bid_s_o          <= '0;
      bresp_s_o        <= '0;
      rvalid_s_o       <= 1'b0;
      rid_s_o          <= '0;
      rdata_s_o        <= '0;
      rresp_s_o        <= '0;
      rlast_s_o        <= 1'b0;
      glb_en_o         <= 1'b0;
      glb_addr_o       <= '0;
      glb_write_data_o <= '0;
      glb_web_o        <= '1;
    end else begin
      wready_s_o <= (state_d == WR_DATA);
      glb_en_o   <= 1'b0;
      glb_web_o  <= '1;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (aw_hs) begin
            addr_q  <= aw_off;
            len_q   <= awlen_s_i;
            burst_q <= awburst_s_i;
            err_q   <= aw_err;
            bid_s_o <= awid_s_i;
          end else if (ar_hs) begin
            addr_q     <= ar_off;
            len_q      <= arlen_s_i;
            burst_q    <= arburst_s_i;
            err_q      <= ar_err;
            rid_s_o    <= arid_s_i;
            glb_en_o   <= !oob_ar;
            glb_addr_o <= ar_off & LOC_MASK;
          end
        end
        WR_DATA: if (w_hs) begin
          glb_en_o         <= !oob_cur;
          glb_web_o        <= oob_cur ? '1 : ~wstrb_s_i;
          glb_write_data_o <= wdata_s_i;
          glb_addr_o       <= addr_q & LOC_MASK;
          addr_q           <= addr_nxt;
          beat_q           <= beat_q + 1'b1;
          err_q            <= worst(err_q, w_err);
          if (beat_last) bresp_s_o <= worst(err_q, w_err);
        end
        WR_RESP: bvalid_s_o <= !b_hs;
        RD_CAP: begin
          rvalid_s_o <= 1'b1;
          rdata_s_o  <= oob_cur ? '0 : glb_read_data_i;
          rresp_s_o  <= oob_cur ? 2'b11 : err_q;
          rlast_s_o  <= beat_last;
        end
        RD_DATA: if (r_hs) begin
          rvalid_s_o <= 1'b0;
          rlast_s_o  <= 1'b0;
          if (!rlast_s_o) begin
            addr_q     <= addr_nxt;
            beat_q     <= beat_q + 1'b1;
            glb_en_o   <= !oob_nxt;
            glb_addr_o <= addr_nxt & LOC_MASK;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_glb_axi_slave.sv
// Directed bench for glb_axi_slave: writes, partial strobes, reads with backpressure, arbitration,
// out-of-window address and mid-burst reset, each compared against hand-computed values.
module tb_glb_axi_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, glb_web;
  logic        glb_en;
  logic [31:0] glb_addr, glb_wdata;
  logic [31:0] glb_rdata = 32'h0;
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  glb_axi_slave dut (
    .clk(clk), .rst(rst),
    .awid_s_i(awid), .awaddr_s_i(awaddr), .awlen_s_i(awlen), .awsize_s_i(awsize),
    .awburst_s_i(awburst), .awvalid_s_i(awvalid), .awready_s_o(awready),
    .wdata_s_i(wdata), .wstrb_s_i(wstrb), .wlast_s_i(wlast), .wvalid_s_i(wvalid), .wready_s_o(wready),
    .bid_s_o(bid), .bresp_s_o(bresp), .bvalid_s_o(bvalid), .bready_s_i(bready),
    .arid_s_i(arid), .araddr_s_i(araddr), .arlen_s_i(arlen), .arsize_s_i(arsize),
    .arburst_s_i(arburst), .arvalid_s_i(arvalid), .arready_s_o(arready),
    .rid_s_o(rid), .rdata_s_o(rdata), .rresp_s_o(rresp), .rlast_s_o(rlast),
    .rvalid_s_o(rvalid), .rready_s_i(rready),
    .glb_en_o(glb_en), .glb_addr_o(glb_addr), .glb_write_data_o(glb_wdata),
    .glb_web_o(glb_web), .glb_read_data_i(glb_rdata)
  );

  // GLB SRAM read model: one-cycle read latency from preloaded words
  always @(posedge clk) begin
    if (glb_en && glb_web == 4'hF)
      glb_rdata <= mem.exists(glb_addr) ? mem[glb_addr] : 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[32'h100] = 32'h1234_5678;
    mem[32'h104] = 32'h9ABC_DEF0;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    step(); step();

    // reset state
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_glb_en", 32'(glb_en), 0);
    chk("rst_glb_web", 32'(glb_web), 32'hF);
    chk("rst_glb_addr", glb_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", 32'(bresp), 0);
    rst = 1'b0;
    #1;
    chk("idle_awready", 32'(awready), 1);
    chk("idle_arready", 32'(arready), 1);

    // INCR write, len=3
    awid = 4'd5; awaddr = 32'h10; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("incr_wready", 32'(wready), 1);
    chk("incr_no_early_en", 32'(glb_en), 0);
    for (int i = 0; i < 4; i++) begin
      wdata = 32'hA0 + 32'(i); wstrb = 4'hF; wlast = (i == 3); wvalid = 1'b1;
      step();
      chk("incr_en", 32'(glb_en), 1);
      chk("incr_addr", glb_addr, 32'h10 + 32'(4 * i));
      chk("incr_wdata", glb_wdata, 32'hA0 + 32'(i));
      chk("incr_web", 32'(glb_web), 0);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("incr_wready_drop", 32'(wready), 0);
    chk("incr_bvalid_t1", 32'(bvalid), 0);
    step();
    chk("incr_bvalid_t2", 32'(bvalid), 1);
    chk("incr_bid", 32'(bid), 5);
    chk("incr_bresp", 32'(bresp), 0);
    chk("incr_glb_idle", 32'(glb_web), 32'hF);
    step();
    chk("incr_bvalid_hold", 32'(bvalid), 1);
    bready = 1'b1;
    step();
    chk("incr_bvalid_clear", 32'(bvalid), 0);
    bready = 1'b0;

    // FIXED burst, partial strobes
    awid = 4'd2; awaddr = 32'h40; awlen = 8'd1; awburst = 2'b00; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h5500 + 32'(i); wstrb = 4'b0101; wlast = (i == 1); wvalid = 1'b1;
      step();
      chk("fixed_en", 32'(glb_en), 1);
      chk("fixed_addr", glb_addr, 32'h40);
      chk("fixed_web", 32'(glb_web), 32'hA);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    step();
    chk("fixed_bvalid", 32'(bvalid), 1);
    chk("fixed_bid", 32'(bid), 2);
    chk("fixed_bresp", 32'(bresp), 0);
    step();
    chk("fixed_bvalid_clear", 32'(bvalid), 0);
    bready = 1'b0;

    // Two-beat read with 5 cycles of R backpressure
    arid = 4'd9; araddr = 32'h100; arlen = 8'd1; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("rd_arready", 32'(arready), 1);
    step();
    arvalid = 1'b0;
    chk("rd_req_en", 32'(glb_en), 1);
    chk("rd_req_web", 32'(glb_web), 32'hF);
    chk("rd_req_addr", glb_addr, 32'h100);
    step();
    chk("rd_cap_en", 32'(glb_en), 0);
    chk("rd_cap_rvalid", 32'(rvalid), 0);
    step();
    chk("rd_b0_rvalid", 32'(rvalid), 1);
    chk("rd_b0_rdata", rdata, 32'h1234_5678);
    chk("rd_b0_rlast", 32'(rlast), 0);
    chk("rd_b0_rid", 32'(rid), 9);
    chk("rd_b0_rresp", 32'(rresp), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rd_stall_rvalid", 32'(rvalid), 1);
      chk("rd_stall_rdata", rdata, 32'h1234_5678);
    end
    rready = 1'b1;
    step();
    chk("rd_b1_rvalid_drop", 32'(rvalid), 0);
    chk("rd_b1_en", 32'(glb_en), 1);
    chk("rd_b1_addr", glb_addr, 32'h104);
    step(); step();
    chk("rd_b1_rvalid", 32'(rvalid), 1);
    chk("rd_b1_rdata", rdata, 32'h9ABC_DEF0);
    chk("rd_b1_rlast", 32'(rlast), 1);
    step();
    chk("rd_done_rvalid", 32'(rvalid), 0);
    rready = 1'b0;
    #1;
    chk("rd_done_arready", 32'(arready), 1);

    // AW and AR together: write wins, read follows after B
    awid = 4'd3; awaddr = 32'h20; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd7; araddr = 32'h104; arlen = 8'd0; arvalid = 1'b1;
    #1;
    chk("arb_arready", 32'(arready), 0);
    chk("arb_awready", 32'(awready), 1);
    step();
    awvalid = 1'b0;
    #1;
    chk("arb_arready_wr", 32'(arready), 0);
    wdata = 32'hCAFE_0001; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    chk("arb_wr_en", 32'(glb_en), 1);
    chk("arb_wr_addr", glb_addr, 32'h20);
    bready = 1'b1;
    step();
    chk("arb_bvalid", 32'(bvalid), 1);
    chk("arb_bid", 32'(bid), 3);
    chk("arb_arready_b", 32'(arready), 0);
    step();
    bready = 1'b0;
    chk("arb_bvalid_clear", 32'(bvalid), 0);
    chk("arb_arready_idle", 32'(arready), 1);
    step();
    arvalid = 1'b0;
    chk("arb_rd_en", 32'(glb_en), 1);
    chk("arb_rd_addr", glb_addr, 32'h104);
    rready = 1'b1;
    step(); step();
    chk("arb_rvalid", 32'(rvalid), 1);
    chk("arb_rdata", rdata, 32'h9ABC_DEF0);
    chk("arb_rid", 32'(rid), 7);
    chk("arb_rlast", 32'(rlast), 1);
    step();
    chk("arb_rvalid_clear", 32'(rvalid), 0);
    rready = 1'b0;

    // Address one past the GLB window
    awid = 4'd1; awaddr = 32'h0001_0000; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
`ifdef GLB_AXI_SLV_ERR_EN
    chk("oob_en", 32'(glb_en), 0);
`else
    chk("oob_en", 32'(glb_en), 1);
    chk("oob_wrap_addr", glb_addr, 32'h0);
`endif
    bready = 1'b1;
    step();
    chk("oob_bvalid", 32'(bvalid), 1);
`ifdef GLB_AXI_SLV_ERR_EN
    chk("oob_bresp", 32'(bresp), 3);
`else
    chk("oob_bresp", 32'(bresp), 0);
`endif
    step();
    bready = 1'b0;

    // Reset during RD_DATA of a len=7 burst, then a fresh read
    arid = 4'd4; araddr = 32'h200; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step(); step();
    chk("rr_rvalid", 32'(rvalid), 1);
    chk("rr_rlast", 32'(rlast), 0);
    rst = 1'b1;
    step();
    chk("rr_rvalid_rst", 32'(rvalid), 0);
    chk("rr_web_rst", 32'(glb_web), 32'hF);
    chk("rr_en_rst", 32'(glb_en), 0);
    chk("rr_rid_rst", 32'(rid), 0);
    rst = 1'b0;
    arid = 4'd6; araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
    #1;
    chk("rr_arready", 32'(arready), 1);
    step();
    arvalid = 1'b0;
    chk("rr_new_en", 32'(glb_en), 1);
    chk("rr_new_addr", glb_addr, 32'h100);
    rready = 1'b1;
    step(); step();
    chk("rr_new_rvalid", 32'(rvalid), 1);
    chk("rr_new_rdata", rdata, 32'h1234_5678);
    chk("rr_new_rid", 32'(rid), 6);
    step();
    chk("rr_new_rvalid_clear", 32'(rvalid), 0);
    rready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
